// File: rtl/aes_key_pkg.sv
// Shared types and constants for the AES-128 key-schedule sequencer.
// Also carries the FIPS-197 reference key and its final round key for benches.
package aes_key_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] key_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_REQ,
        ST_WAIT,
        ST_MIX
    } ks_state_t;

    localparam key_t FIPS_KEY  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam key_t FIPS_RK10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

    // XOR chain that turns the previous round key and G's word into the next round key.
    function automatic key_t expand_round(input key_t prev, input word_t g);
        word_t n0;
        word_t n1;
        word_t n2;
        word_t n3;
        n0 = prev[127:96] ^ g;
        n1 = prev[95:64]  ^ n0;
        n2 = prev[63:32]  ^ n1;
        n3 = prev[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

endpackage

// File: rtl/round_key_store.sv
// Register file holding every round key, one write port and a registered read port.
// Out-of-range read indices return zero.
module round_key_store
    import aes_key_pkg::*;
#(
    parameter int NUM_KEYS = NUM_ROUNDS + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [3:0]   wr_idx,
    input  logic [127:0] wr_data,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_data
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_KEYS - 1);

    key_t slots_q [NUM_KEYS];
    key_t slots_d [NUM_KEYS];
    key_t rd_data_q;
    key_t rd_data_d;

    always_comb begin
        slots_d = slots_q;
        if (wr_en && (wr_idx <= LAST_IDX)) begin
            slots_d[wr_idx] = wr_data;
        end
    end

    // Reads see the pre-write contents, so a same-cycle read of the written slot is old data.
    always_comb begin
        rd_data_d = '0;
        if (rd_idx <= LAST_IDX) begin
            rd_data_d = slots_q[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slots_q   <= '{default: '0};
            rd_data_q <= '0;
        end else begin
            slots_q   <= slots_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/key_expansion.sv
// AES-128 key-schedule sequencer: drives an external G block over an enable/done
// handshake and stores all round keys for random-access reads.
//
//   state | meaning
//   IDLE  | waiting for start; key_in latched on start
//   LOAD  | write round key 0, set round to 1
//   REQ   | one-cycle g_enable pulse for the current round
//   WAIT  | hold g_input/g_round, capture g_output on g_done
//   MIX   | XOR-chain captured word into next round key and store it
module key_expansion
    import aes_key_pkg::*;
#(
    parameter int NUM_ROUNDS = aes_key_pkg::NUM_ROUNDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         ready,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key,
    output logic         g_enable,
    output logic [31:0]  g_input,
    output logic [3:0]   g_round,
    input  logic [31:0]  g_output,
    input  logic         g_done
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    ks_state_t  state_q, state_d;
    logic [3:0] round_q, round_d;
    key_t       prev_q, prev_d;
    word_t      g_cap_q, g_cap_d;
    logic       ready_q, ready_d;

    logic       wr_en;
    logic [3:0] wr_idx;
    key_t       wr_data;
    key_t       next_key;

    assign next_key = expand_round(prev_q, g_cap_q);

    // prev_q doubles as the latched cipher key before LOAD and the latest round key after.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        prev_d  = prev_q;
        g_cap_d = g_cap_q;
        ready_d = ready_q;
        wr_en   = 1'b0;
        wr_idx  = round_q;
        wr_data = prev_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    prev_d  = key_in;
                    ready_d = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                wr_en   = 1'b1;
                wr_idx  = 4'd0;
                round_d = 4'd1;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (g_done) begin
                    g_cap_d = g_output;
                    state_d = ST_MIX;
                end
            end
            ST_MIX: begin
                wr_en   = 1'b1;
                wr_idx  = round_q;
                wr_data = next_key;
                prev_d  = next_key;
                if (round_q == LAST_ROUND) begin
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    round_d = round_q + 4'd1;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            prev_q  <= '0;
            g_cap_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            prev_q  <= prev_d;
            g_cap_q <= g_cap_d;
            ready_q <= ready_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign ready    = ready_q;
    assign g_enable = (state_q == ST_REQ);
    assign g_input  = prev_q[31:0];
    assign g_round  = round_q;

    round_key_store #(
        .NUM_KEYS(NUM_ROUNDS + 1)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_idx  (rd_round),
        .rd_data (rd_key)
    );

endmodule

// File: tb/tb_key_expansion.sv
// Bench for key_expansion: a behavioural G with programmable latency, directed key runs,
// a read-port sweep table and hand-written reset/spurious-input sequences.
module tb_key_expansion;
    import aes_key_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         ready;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;
    logic         g_enable;
    logic [31:0]  g_input;
    logic [3:0]   g_round;
    logic [31:0]  g_output;
    logic         g_done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    key_expansion dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .ready    (ready),
        .rd_round (rd_round),
        .rd_key   (rd_key),
        .g_enable (g_enable),
        .g_input  (g_input),
        .g_round  (g_round),
        .g_output (g_output),
        .g_done   (g_done)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] g_ref(input logic [31:0] w, input logic [3:0] r);
        logic [31:0] rot = {w[23:0], w[31:24]};
        return {sbox(rot[31:24]) ^ rcon(r), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    endfunction

    // Behavioural G: latency lat_v edges from the g_enable edge to g_done sampled high.
    // Driven on the falling edge so the DUT sees it settled at the rising edge.
    int          lat_v = 1;
    bit          spur_en = 1'b0;
    logic        spur_force = 1'b0;
    logic        stub_pend;
    int          stub_cnt;
    logic [31:0] stub_word;
    logic [31:0] held_in;
    logic [3:0]  held_rd;
    logic        sp_mix;
    logic        sp_req;
    int          stab_total;
    int          en_total;
    int          dbl_total;
    logic        en_prev;

    initial begin
        stub_pend = 1'b0; stub_cnt = 0; stub_word = '0; held_in = '0; held_rd = '0;
        sp_mix = 1'b0; sp_req = 1'b0; stab_total = 0; en_total = 0; dbl_total = 0;
        en_prev = 1'b0;
    end

    always @(negedge clk) begin
        sp_req <= sp_mix;
        sp_mix <= 1'b0;
        if (rst || !busy) begin
            stub_pend <= 1'b0;
        end else if (g_enable) begin
            stub_pend <= 1'b1;
            stub_cnt  <= lat_v;
            held_in   <= g_input;
            held_rd   <= g_round;
            stub_word <= g_ref(g_input, g_round);
        end else if (stub_pend) begin
            if (stub_cnt == 0) begin
                stub_pend <= 1'b0;
                sp_mix    <= spur_en;
            end else begin
                stub_cnt <= stub_cnt - 1;
                if (g_input !== held_in || g_round !== held_rd) stab_total <= stab_total + 1;
            end
        end
    end

    always @(negedge clk) begin
        en_prev <= g_enable;
        if (g_enable) en_total <= en_total + 1;
        if (g_enable && en_prev) dbl_total <= dbl_total + 1;
    end

    assign g_done   = (stub_pend && stub_cnt == 0) || sp_mix || sp_req || spur_force;
    assign g_output = stub_word;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns rd_key one rising edge after rd_round is applied.
    task automatic read_slot(input logic [3:0] idx, output logic [127:0] val);
        rd_round = idx;
        @(negedge clk);
        val = rd_key;
    endtask

    task automatic run_key(input logic [127:0] key, input int lat, input bit spur,
                           input bit mid_start, input string tag);
        int cyc;
        int en0;
        int dbl0;
        int st0;
        bit seen;
        lat_v   = lat;
        spur_en = spur;
        en0  = en_total;
        dbl0 = dbl_total;
        st0  = stab_total;
        key_in = key;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        key_in = ~key;
        chk({tag, "_ready_cleared"}, ready, 0);
        chk({tag, "_busy_load"}, busy, 1);
        cyc  = 1;
        seen = 1'b0;
        while (!ready && cyc < 2000) begin
            if (g_enable && !seen) begin
                seen = 1'b1;
                chk({tag, "_first_g_input"}, g_input, key[31:0]);
                chk({tag, "_first_g_round"}, g_round, 1);
            end
            start = mid_start && (cyc == 25);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        // cyc counts cycles after the start edge; the LOAD cycle is cycle 1.
        chk({tag, "_ready_cycle"}, cyc, 2 + 10 * (lat + 2));
        chk({tag, "_g_enable_pulses"}, en_total - en0, 10);
        chk({tag, "_g_enable_double"}, dbl_total - dbl0, 0);
        chk({tag, "_g_input_stable"}, stab_total - st0, 0);
        spur_en = 1'b0;
    endtask

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] exp;
    } rd_vec_t;

    logic [127:0] rk [11];
    rd_vec_t      vecs [16];
    logic [127:0] val;

    initial begin
        rst = 1'b1; start = 1'b0; key_in = '0; rd_round = 4'd0;

        rk[0]  = FIPS_KEY;
        rk[1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
        rk[2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
        rk[3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
        rk[4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
        rk[5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
        rk[6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
        rk[7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
        rk[8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
        rk[9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
        rk[10] = FIPS_RK10;
        for (int i = 0; i < 16; i++) begin
            vecs[i].idx = 4'(i);
            vecs[i].exp = (i <= 10) ? rk[i] : 128'h0;
        end

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 0);
        chk("rst_g_enable", g_enable, 0);
        chk("rst_g_input", g_input, 0);
        chk("rst_g_round", g_round, 0);
        chk("rst_rd_key", rd_key, 0);

        // FIPS-197 key, minimum latency, full read sweep including out-of-range indices
        run_key(FIPS_KEY, 1, 1'b0, 1'b0, "fips_l1");
        for (int i = 0; i < 16; i++) begin
            read_slot(vecs[i].idx, val);
            chk($sformatf("sweep_slot%0d", i), val, vecs[i].exp);
        end

        // Long latency with spurious g_done in MIX/REQ and a start pulse while busy
        run_key(FIPS_KEY, 7, 1'b1, 1'b1, "fips_l7");
        read_slot(4'd1, val);
        chk("fips_l7_slot1", val, rk[1]);
        read_slot(4'd10, val);
        chk("fips_l7_slot10", val, FIPS_RK10);

        // Spurious g_done while idle
        spur_force = 1'b1;
        @(negedge clk);
        spur_force = 1'b0;
        @(negedge clk);
        chk("idle_done_busy", busy, 0);
        chk("idle_done_ready", ready, 1);
        read_slot(4'd10, val);
        chk("idle_done_slot10", val, FIPS_RK10);

        run_key(128'h0, 2, 1'b0, 1'b0, "zero_l2");
        read_slot(4'd1, val);
        chk("zero_slot1", val, 128'h62636363_62636363_62636363_62636363);
        read_slot(4'd10, val);
        chk("zero_slot10", val, 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e);

        // Reset during the round-5 WAIT
        lat_v  = 4;
        key_in = FIPS_KEY;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int guard = 0;
            while (!(g_enable && g_round == 4'd5) && guard < 500) begin
                @(negedge clk);
                guard++;
            end
            chk("rst_mid_reached_round5", guard < 500, 1);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", ready, 0);
        chk("rst_mid_g_enable", g_enable, 0);
        chk("rst_mid_g_input", g_input, 0);
        chk("rst_mid_g_round", g_round, 0);
        chk("rst_mid_rd_key", rd_key, 0);
        rst = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            read_slot(4'(i), val);
            chk($sformatf("rst_mid_slot%0d", i), val, 128'h0);
        end

        run_key(FIPS_KEY, 3, 1'b0, 1'b0, "after_rst_l3");
        read_slot(4'd0, val);
        chk("after_rst_slot0", val, FIPS_KEY);
        read_slot(4'd5, val);
        chk("after_rst_slot5", val, rk[5]);
        read_slot(4'd10, val);
        chk("after_rst_slot10", val, FIPS_RK10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/key_expansion.md
# key_expansion

AES-128 key-schedule sequencer that sits directly downstream of the existing `G` round-word block. It loads a 128-bit cipher key, runs the ten expansion rounds by driving `G` over an enable/done handshake, XOR-chains `G`'s output into the four words of each new round key, and stores all 11 round keys for random-access reads by the cipher datapath.

## Interface

Parameters:
- `NUM_ROUNDS`, 10: number of expansion rounds; round keys stored = `NUM_ROUNDS`+1.

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  sampled in IDLE only; begins expansion of `key_in`
- `key_in`  in  128  cipher key; w0 = [127:96] … w3 = [31:0]; sampled on the `start` edge
- `busy`  out  1  high from the cycle after `start` until the last round key is written
- `ready`  out  1  all 11 round keys valid; cleared by `start`
- `rd_round`  in  4  round-key index 0..10
- `rd_key`  out  128  registered read of round key `rd_round`
- `g_enable`  out  1  one-cycle request pulse to `G`
- `g_input`  out  32  word w[4r-1] for `G`
- `g_round`  out  4  round number r (1..10) for `G`
- `g_output`  in  32  `G` result
- `g_done`  in  1  `G` result valid

## Operation

- States: IDLE, LOAD, REQ, WAIT, MIX.
- IDLE: `start`=1 latches `key_in`, clears `ready` -> LOAD. `start` is ignored in every other state.
- LOAD: write round key 0 = latched key; r <= 1 -> REQ.
- REQ: `g_enable`=1 for exactly this cycle; `g_input` = prev_key[31:0]; `g_round` = r -> WAIT.
- WAIT: hold `g_input`/`g_round` stable; on `g_done`=1 capture `g_output` -> MIX. `g_done` outside WAIT is ignored.
- MIX: with p = round key r-1 and g = captured output: n0 = p0^g, n1 = p1^n0, n2 = p2^n1, n3 = p3^n2. Write {n0,n1,n2,n3} to slot r. If r = NUM_ROUNDS -> IDLE, `ready` <= 1; else r <= r+1 -> REQ.
- Storage: 11×128 registers, with one write per LOAD/MIX cycle.
- Read: `rd_key` <= slot[`rd_round`] every cycle, regardless of state. `rd_round` > 10 returns 0. While `busy`, reads return current contents (partially updated); consumers gate reads on `ready`.
- `busy` = state ≠ IDLE.

## Timing

- Reset: state IDLE; r=0; all slots, `rd_key`, `g_input`, `g_round` = 0; `g_enable`, `busy`, `ready` = 0.
- `start` sampled at edge T: LOAD during cycle T+1, REQ at T+2.
- Per round: 1 REQ cycle + L WAIT cycles + 1 MIX cycle, where L ≥ 1 is `G` latency from the `g_enable` edge to `g_done` sampled high.
- Total: `ready` rises 2 + 10·(L+2) cycles after the `start` edge.
- `g_done` already high in the first WAIT cycle is accepted (minimum L = 1).
- `rst` mid-expansion: the next edge gives full reset values. No partial keys survive; `G` requests are abandoned.
- `rd_key` latency: 1 cycle from `rd_round`. A read of the slot being written in the same cycle returns the old value.

## Structure

- Package `aes_key_pkg` holds:
  - `NUM_ROUNDS`
  - `word_t` (32b) and `key_t` (128b) typedefs
  - the state enum `ks_state_t`
  - an FIPS-197 reference key and round-10 key constant for benches
- `G` is not instantiated inside; it is connected at the parent level through the `g_*` ports. The only natural sub-module is `round_key_store` (11×128 register file with registered read).

## Test plan

- **FIPS-197 key.** Drive `key_in`=2b7e1516_28aed2a6_abf71588_09cf4f3c with real `G`.
  - First request: `g_input`=09cf4f3c, `g_round`=1, `G` returns 8b84eb01.
  - Slot 1 = a0fafe17_88542cb1_23a33939_2a6c7605.
  - Slot 10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
  - `ready` after 2+10·(L+2) cycles.
- **Zero key.** 0…0 -> slot 1 = 62636363_62636363_62636363_62636363; slot 10 = b4ef5bcb_3e92e211_23e951cf_6f8f188e.
- **Handshake stall.** Stub `G` with L = 1, then L = 7.
  - `g_enable` is exactly one cycle per round, 10 pulses total.
  - `g_input` is stable through WAIT.
  - Keys are identical to the FIPS-197 case.
- **Spurious inputs.**
  - `g_done` pulsed in IDLE/REQ/MIX: no state change.
  - `start` pulsed while `busy`: ignored, results unchanged.
- **Reset mid-round.** Assert `rst` during round 5 WAIT -> next cycle all outputs 0, `busy`=0, and slot reads return 0. A fresh `start` completes correctly.
- **Read port.** After `ready`, sweep `rd_round` 0..15.
  - Slots 0..10 match the FIPS-197 values with 1-cycle latency.
  - 11..15 return 0.
